// File: rtl/axis_block_checker.sv
`default_nettype none
// ============================================================================
// axis_block_checker : 2-entry AXI-Stream register slice with block-pattern
//                      and block-length checking plus PS-readable counters.
// Revision: 1.0
// ============================================================================
module axis_block_checker #(
  parameter int unsigned BYTES_PER_BLOCK = 16384,
  parameter int unsigned ERR_CNT_W       = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 clr_stats,
  input  logic [31:0]          s_axis_tdata,
  input  logic [3:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic [3:0]           m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [31:0]          frame_cnt,
  output logic [ERR_CNT_W-1:0] err_data_cnt,
  output logic [ERR_CNT_W-1:0] err_len_cnt,
  output logic                 err_sticky
);

  localparam int unsigned WORDS = BYTES_PER_BLOCK / 4;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [31:0]          m_data_q, m_data_d;
  logic [3:0]           m_keep_q, m_keep_d;
  logic                 m_last_q, m_last_d;
  logic                 m_valid_q, m_valid_d;
  logic [31:0]          s_data_q, s_data_d;
  logic [3:0]           s_keep_q, s_keep_d;
  logic                 s_last_q, s_last_d;
  logic                 s_valid_q, s_valid_d;
  logic                 s_ready_q, s_ready_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          frame_cnt_q, frame_cnt_d;
  logic [ERR_CNT_W-1:0] err_data_cnt_q, err_data_cnt_d;
  logic [ERR_CNT_W-1:0] err_len_cnt_q, err_len_cnt_d;
  logic                 err_sticky_q, err_sticky_d;

  logic                 in_hs;
  logic                 out_hs;
  logic [31:0]          idx_ext;
  logic [31:0]          exp_data;
  logic                 exp_last;
  logic                 data_err;
  logic                 len_err;

  // Register slice: M feeds the output, S catches the beat accepted while M stalls.
  always_comb begin
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    s_data_d  = s_data_q;
    s_keep_d  = s_keep_q;
    s_last_d  = s_last_q;
    s_valid_d = s_valid_q;
    in_hs     = s_axis_tvalid && s_ready_q;
    out_hs    = m_valid_q && m_axis_tready;
    if (!m_valid_q || out_hs) begin
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        m_keep_d  = s_keep_q;
        m_last_d  = s_last_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = in_hs;
        if (in_hs) begin
          m_data_d = s_axis_tdata;
          m_keep_d = s_axis_tkeep;
          m_last_d = s_axis_tlast;
        end
      end
    end else if (in_hs) begin
      s_data_d  = s_axis_tdata;
      s_keep_d  = s_axis_tkeep;
      s_last_d  = s_axis_tlast;
      s_valid_d = 1'b1;
    end
    s_ready_d = !s_valid_d;
  end

  always_comb begin
    idx_ext  = 32'(idx_q);
    exp_data = {24'hAAAAAA, idx_ext[7:0]};
    exp_last = (idx_ext == WORDS - 1);
    data_err = in_hs && ((s_axis_tdata != exp_data) || (s_axis_tkeep != 4'hF));
    len_err  = in_hs && (s_axis_tlast != exp_last);
    idx_d    = idx_q;
    if (in_hs) begin
      idx_d = (s_axis_tlast || exp_last) ? '0 : idx_q + 1'b1;
    end
  end

  // Clear has priority over any increment in the same cycle.
  always_comb begin
    frame_cnt_d    = frame_cnt_q;
    err_data_cnt_d = err_data_cnt_q;
    err_len_cnt_d  = err_len_cnt_q;
    err_sticky_d   = err_sticky_q;
    if (clr_stats) begin
      frame_cnt_d    = '0;
      err_data_cnt_d = '0;
      err_len_cnt_d  = '0;
      err_sticky_d   = 1'b0;
    end else begin
      if (in_hs && s_axis_tlast) begin
        frame_cnt_d = frame_cnt_q + 32'd1;
      end
      if (data_err && (err_data_cnt_q != ERR_MAX)) begin
        err_data_cnt_d = err_data_cnt_q + 1'b1;
      end
      if (len_err && (err_len_cnt_q != ERR_MAX)) begin
        err_len_cnt_d = err_len_cnt_q + 1'b1;
      end
      if (data_err || len_err) begin
        err_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_data_q       <= '0;
      m_keep_q       <= '0;
      m_last_q       <= 1'b0;
      m_valid_q      <= 1'b0;
      s_data_q       <= '0;
      s_keep_q       <= '0;
      s_last_q       <= 1'b0;
      s_valid_q      <= 1'b0;
      s_ready_q      <= 1'b0;
      idx_q          <= '0;
      frame_cnt_q    <= '0;
      err_data_cnt_q <= '0;
      err_len_cnt_q  <= '0;
      err_sticky_q   <= 1'b0;
    end else begin
      m_data_q       <= m_data_d;
      m_keep_q       <= m_keep_d;
      m_last_q       <= m_last_d;
      m_valid_q      <= m_valid_d;
      s_data_q       <= s_data_d;
      s_keep_q       <= s_keep_d;
      s_last_q       <= s_last_d;
      s_valid_q      <= s_valid_d;
      s_ready_q      <= s_ready_d;
      idx_q          <= idx_d;
      frame_cnt_q    <= frame_cnt_d;
      err_data_cnt_q <= err_data_cnt_d;
      err_len_cnt_q  <= err_len_cnt_d;
      err_sticky_q   <= err_sticky_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_data_cnt  = err_data_cnt_q;
  assign err_len_cnt   = err_len_cnt_q;
  assign err_sticky    = err_sticky_q;

endmodule
`default_nettype wire
